// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit FND scan controller: FSM state codes,
// active-low segment patterns and the BCD-to-segment lookup.
package fnd_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [1:0] ST_OFF = 2'd0;
   localparam logic [1:0] ST_ON  = 2'd1;
   localparam logic [1:0] ST_GAP = 2'd2;

   // Active-low, bit 7 = dp, bits 6..0 = g..a
   localparam logic [7:0] SEG_0       = 8'hC0;
   localparam logic [7:0] SEG_1       = 8'hF9;
   localparam logic [7:0] SEG_2       = 8'hA4;
   localparam logic [7:0] SEG_3       = 8'hB0;
   localparam logic [7:0] SEG_4       = 8'h99;
   localparam logic [7:0] SEG_5       = 8'h92;
   localparam logic [7:0] SEG_6       = 8'h82;
   localparam logic [7:0] SEG_7       = 8'hF8;
   localparam logic [7:0] SEG_8       = 8'h80;
   localparam logic [7:0] SEG_9       = 8'h90;
   localparam logic [7:0] SEG_DP_ONLY = 8'h7F;
   localparam logic [7:0] SEG_BLANK   = 8'hFF;

   function automatic logic [7:0] seg_code(input logic [3:0] bcd);
      logic [7:0] code;
      case (bcd)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         4'hA:    code = SEG_DP_ONLY;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/fnd_scan_timer.sv
// Dwell timer for the FND scanner: counts cycles spent lit (ON) and blanked
// (GAP) and strobes expire on the last cycle of each.
module fnd_scan_timer
   import fnd_pkg::*;
#(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] state,
   input  logic       clear,
   output logic       on_expire,
   output logic       gap_expire
);

   localparam int PW = $clog2(PRESCALE + 1);
   localparam int GW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [PW-1:0] ON_LAST  = PW'(PRESCALE - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   logic [PW-1:0] on_count;
   logic [GW-1:0] gap_count;

   // The top pulses clear on every state/digit change, so each dwell starts at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         on_count  <= '0;
         gap_count <= '0;
      end else if (clear) begin
         on_count  <= '0;
         gap_count <= '0;
      end else begin
         if (state == ST_ON)  on_count  <= on_count + PW'(1);
         if (state == ST_GAP) gap_count <= gap_count + GW'(1);
      end
   end

   assign on_expire  = (state == ST_ON)  && (on_count == ON_LAST);
   assign gap_expire = (state == ST_GAP) && (gap_count == GAP_LAST);

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scanner with inter-digit blanking and per-frame
// input snapshot. Optional leading-zero blanking via FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_en,
   input  logic [15:0]           i_digits,
   input  logic [NUM_DIGITS-1:0] i_dp,
   output logic [NUM_DIGITS-1:0] o_fndSelect,
   output logic [7:0]            o_fndData,
   output logic [1:0]            o_digitIdx,
   output logic                  o_frameStart
);

   logic [1:0]            state, state_nxt;
   logic [1:0]            idx, idx_nxt;
   logic                  take_snap, transition;
   logic                  on_expire, gap_expire;
   logic [15:0]           snap_digits, snap_digits_nxt;
   logic [NUM_DIGITS-1:0] snap_dp, snap_dp_nxt;
   logic [3:0]            nibble;
   logic                  lead_zero;
   logic [7:0]            code;
   logic [NUM_DIGITS-1:0] select_nxt;
   logic [7:0]            data_nxt;

   fnd_scan_timer #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) timer (
      .clk        (i_clk),
      .rst_n      (i_reset_n),
      .state      (state),
      .clear      (transition),
      .on_expire  (on_expire),
      .gap_expire (gap_expire)
   );

   // Snapshot is only refreshed when the scan lands on digit 0
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      take_snap = 1'b0;
      if (!i_en) begin
         state_nxt = ST_OFF;
         idx_nxt   = 2'd0;
      end else begin
         case (state)
            ST_OFF: begin
               state_nxt = ST_ON;
               idx_nxt   = 2'd0;
               take_snap = 1'b1;
            end
            ST_ON: begin
               if (on_expire) begin
                  if (BLANK_CYCLES > 0) begin
                     state_nxt = ST_GAP;
                  end else begin
                     idx_nxt   = idx + 2'd1;
                     take_snap = (idx == 2'd3);
                  end
               end
            end
            ST_GAP: begin
               if (gap_expire) begin
                  state_nxt = ST_ON;
                  idx_nxt   = idx + 2'd1;
                  take_snap = (idx == 2'd3);
               end
            end
            default: begin
               state_nxt = ST_OFF;
               idx_nxt   = 2'd0;
            end
         endcase
      end
   end

   assign transition      = (state_nxt != state) || (idx_nxt != idx);
   assign snap_digits_nxt = take_snap ? i_digits : snap_digits;
   assign snap_dp_nxt     = take_snap ? i_dp : snap_dp;
   assign nibble          = snap_digits_nxt[{idx_nxt, 2'b00} +: 4];

`ifdef FND_LEADING_ZERO_BLANK_EN
   always_comb begin
      lead_zero = 1'b0;
      case (idx_nxt)
         2'd3:    lead_zero = (snap_digits_nxt[15:12] == 4'd0);
         2'd2:    lead_zero = (snap_digits_nxt[15:8] == 8'd0);
         2'd1:    lead_zero = (snap_digits_nxt[15:4] == 12'd0);
         default: lead_zero = 1'b0;
      endcase
   end
`else
   assign lead_zero = 1'b0;
`endif

   // Outputs are computed from next-state values so they change on the transition edge
   always_comb begin
      code = lead_zero ? SEG_BLANK : seg_code(nibble);
      if (snap_dp_nxt[idx_nxt]) code[7] = 1'b0;
      select_nxt = 4'hF;
      data_nxt   = SEG_BLANK;
      if (state_nxt == ST_ON) begin
         select_nxt = ~(4'b0001 << idx_nxt);
         data_nxt   = code;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= ST_OFF;
         idx          <= 2'd0;
         snap_digits  <= '0;
         snap_dp      <= '0;
         o_fndSelect  <= 4'hF;
         o_fndData    <= SEG_BLANK;
         o_frameStart <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         snap_digits  <= snap_digits_nxt;
         snap_dp      <= snap_dp_nxt;
         o_fndSelect  <= select_nxt;
         o_fndData    <= data_nxt;
         o_frameStart <= take_snap;
      end
   end

   assign o_digitIdx = idx;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller (PRESCALE=4, BLANK_CYCLES=2);
// expectations follow FND_LEADING_ZERO_BLANK_EN when it is defined.
module tb_fnd_scan_controller;

   localparam int P     = 4;
   localparam int B     = 2;
   localparam int FRAME = 4 * (P + B);
   localparam int TO_D2 = 2 * (P + B) + 1;

   typedef struct {
      logic [3:0] sel;
      logic [7:0] data;
      logic       fs;
      logic       idxValid;
      logic [1:0] idx;
   } expect_t;

   logic        clock = 1'b0;
   logic        resetN;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  dpReq;
   logic [3:0]  fndSelect;
   logic [7:0]  fndData;
   logic [1:0]  digitIdx;
   logic        frameStart;

   expect_t expQ[$];
   int      vectorCount = 0;
   int      missCount   = 0;

   always #5 clock = ~clock;

   fnd_scan_controller #(
      .PRESCALE     (P),
      .BLANK_CYCLES (B)
   ) dut (
      .i_clk        (clock),
      .i_reset_n    (resetN),
      .i_en         (enable),
      .i_digits     (digits),
      .i_dp         (dpReq),
      .o_fndSelect  (fndSelect),
      .o_fndData    (fndData),
      .o_digitIdx   (digitIdx),
      .o_frameStart (frameStart)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] d, input logic [3:0] dp);
      enable = en;
      digits = d;
      dpReq  = dp;
   endtask

   // Independent segment model built from the display's truth table
   function automatic logic [7:0] modelCode(input logic [15:0] d, input logic [3:0] dp, input int k);
      logic [3:0] nib;
      logic [7:0] c;
      nib = d[k*4 +: 4];
      case (nib)
         4'h0: c = 8'hC0;  4'h1: c = 8'hF9;  4'h2: c = 8'hA4;  4'h3: c = 8'hB0;
         4'h4: c = 8'h99;  4'h5: c = 8'h92;  4'h6: c = 8'h82;  4'h7: c = 8'hF8;
         4'h8: c = 8'h80;  4'h9: c = 8'h90;  4'hA: c = 8'h7F;
         default: c = 8'hFF;
      endcase
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (k > 0 && (d >> (k * 4)) == 16'h0) c = 8'hFF;
`endif
      if (dp[k]) c[7] = 1'b0;
      return c;
   endfunction

   task automatic pushBlank(input int n);
      expect_t e;
      for (int i = 0; i < n; i++) begin
         e = '{sel: 4'hF, data: 8'hFF, fs: 1'b0, idxValid: 1'b1, idx: 2'd0};
         expQ.push_back(e);
      end
   endtask

   task automatic pushFrame(input logic [15:0] d, input logic [3:0] dp);
      expect_t e;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < P; c++) begin
            e.sel      = ~(4'b0001 << k);
            e.data     = modelCode(d, dp, k);
            e.fs       = (k == 0 && c == 0);
            e.idxValid = 1'b1;
            e.idx      = 2'(k);
            expQ.push_back(e);
         end
         for (int c = 0; c < B; c++) begin
            e = '{sel: 4'hF, data: 8'hFF, fs: 1'b0, idxValid: 1'b0, idx: 2'd0};
            expQ.push_back(e);
         end
      end
   endtask

   task automatic runCycles(input int n);
      expect_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (expQ.size() == 0) begin
            checkOutput("scoreboardUnderflow", 32'(expQ.size()), 32'd1);
         end else begin
            e = expQ.pop_front();
            checkOutput("select", 32'(fndSelect), 32'(e.sel));
            checkOutput("data", 32'(fndData), 32'(e.data));
            checkOutput("frameStart", 32'(frameStart), 32'(e.fs));
            if (e.idxValid) checkOutput("digitIdx", 32'(digitIdx), 32'(e.idx));
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetN = 1'b1;
      applyStimulus(1'b0, 16'h0000, 4'h0);
      #1 resetN = 1'b0;
      #1;
      checkOutput("resetSelect", 32'(fndSelect), 32'h0F);
      checkOutput("resetData", 32'(fndData), 32'hFF);
      checkOutput("resetFrameStart", 32'(frameStart), 32'd0);
      checkOutput("resetIdx", 32'(digitIdx), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("resetHoldSelect", 32'(fndSelect), 32'h0F);
      resetN = 1'b1;
      pushBlank(2);
      runCycles(2);

      // Scan order, then a second frame with a mid-frame input change
      applyStimulus(1'b1, 16'h1234, 4'h0);
      pushFrame(16'h1234, 4'h0);
      runCycles(FRAME);
      pushFrame(16'h1234, 4'h0);
      runCycles(TO_D2);
      applyStimulus(1'b1, 16'h5678, 4'h0);
      runCycles(FRAME - TO_D2);
      pushFrame(16'h5678, 4'h0);
      runCycles(FRAME);

      applyStimulus(1'b1, 16'hA0F9, 4'b0011);
      pushFrame(16'hA0F9, 4'b0011);
      runCycles(FRAME);

      // Disable during digit 2, then restart from digit 0
      applyStimulus(1'b1, 16'h0030, 4'h0);
      pushFrame(16'h0030, 4'h0);
      runCycles(TO_D2);
      applyStimulus(1'b0, 16'h0030, 4'h0);
      expQ.delete();
      pushBlank(2);
      runCycles(2);
      applyStimulus(1'b1, 16'h0030, 4'h0);
      pushFrame(16'h0030, 4'h0);
      runCycles(FRAME);

      @(posedge clock);
      #1;
      checkOutput("preResetSelect", 32'(fndSelect), 32'h0E);
      #2 resetN = 1'b0;
      #1;
      checkOutput("midResetSelect", 32'(fndSelect), 32'h0F);
      checkOutput("midResetData", 32'(fndData), 32'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
